fetch_sequencer: RTL and testbench

Control FSM for instruction fetch in JZJCoreF. It drives the instruction-address mux select (`NEXT_PC` / `CURRENT_PC`), the program-counter and instruction-register write enables, and the request/select of the single shared memory port, so instruction fetches and load/store data accesses take turns on that port. It also provides halt/resume control, a memory-timeout watchdog and a saturating stall-cycle counter. It sits between the decoder/halt logic and the MemoryController.

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM for JZJCoreF: arbitrates the shared memory port between
// instruction fetches and load/store accesses, with halt/resume, a memory watchdog and stall counting.
package fetch_sequencer_pkg;
    typedef enum logic {
        CURRENT_PC = 1'b0,
        NEXT_PC    = 1'b1
    } InstructionAddressSource_t;

    typedef enum logic [2:0] {
        S_FETCH_CURRENT = 3'd0,
        S_EXECUTE       = 3'd1,
        S_DATA_ACCESS   = 3'd2,
        S_FETCH_NEXT    = 3'd3,
        S_HALTED        = 3'd4
    } fetch_state_t;
endpackage

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          memAck,
    input  logic                          dataAccessRequest,
    input  logic                          haltRequest,
    input  logic                          resume,
    output InstructionAddressSource_t     instructionAddressSource,
    output logic                          memRequest,
    output logic                          memSelectData,
    output logic                          pcWriteEnable,
    output logic                          irWriteEnable,
    output logic                          dataAccessComplete,
    output logic                          halted,
    output logic                          busError,
    output logic [STALL_COUNT_WIDTH-1:0]  stallCount,
    output fetch_state_t                  debug_state
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STALL_COUNT_WIDTH-1:0] STALL_MAX = '1;

    fetch_state_t                 state_q, state_d;
    logic [WAIT_W-1:0]            wait_q, wait_d;
    logic                         bus_error_q, bus_error_d;
    logic [STALL_COUNT_WIDTH-1:0] stall_q, stall_d;

    logic                      req_raw, sel_raw, halt_raw;
    logic                      pc_we_raw, ir_we_raw, dac_raw;
    InstructionAddressSource_t src_raw;
    logic                      stalled, timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH_CURRENT;
            wait_q      <= '0;
            bus_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_error_d = bus_error_q;
        req_raw     = 1'b0;
        sel_raw     = 1'b0;
        halt_raw    = 1'b0;
        pc_we_raw   = 1'b0;
        ir_we_raw   = 1'b0;
        dac_raw     = 1'b0;
        src_raw     = CURRENT_PC;

        // Request states share the timeout test; an ack on the last allowed cycle wins.
        case (state_q)
            S_FETCH_CURRENT: begin
                req_raw = 1'b1;
                src_raw = CURRENT_PC;
            end
            S_EXECUTE: begin
                src_raw = NEXT_PC;
                if (haltRequest)            state_d = S_HALTED;
                else if (dataAccessRequest) state_d = S_DATA_ACCESS;
                else                        state_d = S_FETCH_NEXT;
            end
            S_DATA_ACCESS: begin
                req_raw = 1'b1;
                sel_raw = 1'b1;
                src_raw = NEXT_PC;
            end
            S_FETCH_NEXT: begin
                req_raw = 1'b1;
                src_raw = NEXT_PC;
            end
            S_HALTED: begin
                halt_raw = 1'b1;
                if (resume && !bus_error_q) state_d = S_FETCH_CURRENT;
            end
            default: state_d = S_FETCH_CURRENT;
        endcase

        stalled = req_raw && !memAck;
        timeout = stalled && (wait_q == WAIT_LAST);

        if (req_raw && memAck) begin
            case (state_q)
                S_FETCH_CURRENT: begin
                    ir_we_raw = 1'b1;
                    state_d   = S_EXECUTE;
                end
                S_DATA_ACCESS: begin
                    dac_raw = 1'b1;
                    state_d = S_FETCH_NEXT;
                end
                S_FETCH_NEXT: begin
                    pc_we_raw = 1'b1;
                    ir_we_raw = 1'b1;
                    state_d   = S_EXECUTE;
                end
                default: ;
            endcase
        end else if (timeout) begin
            state_d     = S_HALTED;
            bus_error_d = 1'b1;
        end

        stall_d = stall_q;
        if (stalled && stall_q != STALL_MAX) stall_d = stall_q + 1'b1;

        wait_d = '0;
        if (stalled && state_d == state_q) wait_d = wait_q + 1'b1;
    end

    // Everything is forced idle while reset is held, even though the state reads FETCH_CURRENT.
    assign memRequest               = reset & req_raw;
    assign memSelectData            = reset & sel_raw;
    assign pcWriteEnable            = reset & pc_we_raw;
    assign irWriteEnable            = reset & ir_we_raw;
    assign dataAccessComplete       = reset & dac_raw;
    assign halted                   = reset & halt_raw;
    assign busError                 = reset & bus_error_q;
    assign stallCount               = reset ? stall_q : '0;
    assign instructionAddressSource = reset ? src_raw : CURRENT_PC;
    assign debug_state              = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 4-cycle watchdog and a 4-bit stall counter.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic memAck = 1'b0;
    logic dataAccessRequest = 1'b0;
    logic haltRequest = 1'b0;
    logic resume = 1'b0;

    InstructionAddressSource_t instructionAddressSource;
    logic memRequest, memSelectData, pcWriteEnable, irWriteEnable;
    logic dataAccessComplete, halted, busError;
    logic [3:0] stallCount;
    fetch_state_t debug_state;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_stall = 4'd0;

    // {state, req, sel, pcwe, irwe, dac, halted, busError, source==CURRENT_PC}
    logic [10:0] obs;
    assign obs = {debug_state, memRequest, memSelectData, pcWriteEnable, irWriteEnable,
                  dataAccessComplete, halted, busError, instructionAddressSource == CURRENT_PC};

    fetch_sequencer #(.TIMEOUT_CYCLES(4), .STALL_COUNT_WIDTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .memAck(memAck),
        .dataAccessRequest(dataAccessRequest),
        .haltRequest(haltRequest),
        .resume(resume),
        .instructionAddressSource(instructionAddressSource),
        .memRequest(memRequest),
        .memSelectData(memSelectData),
        .pcWriteEnable(pcWriteEnable),
        .irWriteEnable(irWriteEnable),
        .dataAccessComplete(dataAccessComplete),
        .halted(halted),
        .busError(busError),
        .stallCount(stallCount),
        .debug_state(debug_state)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        memAck = 1'b1;
        dataAccessRequest = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            e = {S_FETCH_CURRENT, 8'b0000_0001};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%b exp=%b", i, obs, e);
            end
            checks++;
            if (stallCount !== 4'd0) begin
                failures++;
                $display("FAIL reset_stall got=%0d exp=0", stallCount);
            end
            cyc();
        end
        dataAccessRequest = 1'b0;
        reset = 1'b1;
    endtask

    // Ends in EXECUTE.
    task automatic test_back_to_back();
        logic [10:0] e;
        memAck = 1'b1;
        #1;
        e = {S_FETCH_CURRENT, 8'b1001_0001};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL btb_first_fetch got=%b exp=%b", obs, e);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            e = {S_EXECUTE, 8'b0000_0000};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL btb_execute iter=%0d got=%b exp=%b", i, obs, e);
            end
            cyc();
            #1;
            e = {S_FETCH_NEXT, 8'b1011_0000};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL btb_fetch_next iter=%0d got=%b exp=%b", i, obs, e);
            end
            cyc();
        end
    endtask

    // Starts and ends in EXECUTE; three wait states then ack.
    task automatic test_data_access();
        logic [10:0] e;
        dataAccessRequest = 1'b1;
        memAck = 1'b0;
        cyc();
        dataAccessRequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            e = {S_DATA_ACCESS, 8'b1100_0000};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL da_wait iter=%0d got=%b exp=%b", i, obs, e);
            end
            cyc();
        end
        memAck = 1'b1;
        #1;
        e = {S_DATA_ACCESS, 8'b1100_1000};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL da_ack got=%b exp=%b", obs, e);
        end
        cyc();
        #1;
        e = {S_FETCH_NEXT, 8'b1011_0000};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL da_then_fetch_next got=%b exp=%b", obs, e);
        end
        exp_stall = 4'd3;
        checks++;
        if (stallCount !== exp_stall) begin
            failures++;
            $display("FAIL da_stall got=%0d exp=%0d", stallCount, exp_stall);
        end
        cyc();
    endtask

    // Starts in EXECUTE, ends in EXECUTE after a refetch at the current PC.
    task automatic test_halt_priority();
        logic [10:0] e;
        haltRequest = 1'b1;
        dataAccessRequest = 1'b1;
        memAck = 1'b1;
        cyc();
        haltRequest = 1'b0;
        dataAccessRequest = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            e = {S_HALTED, 8'b0000_0101};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL halt_state iter=%0d got=%b exp=%b", i, obs, e);
            end
            cyc();
        end
        checks++;
        if (stallCount !== exp_stall) begin
            failures++;
            $display("FAIL halt_ack_not_counted got=%0d exp=%0d", stallCount, exp_stall);
        end
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        #1;
        e = {S_FETCH_CURRENT, 8'b1001_0001};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL halt_resume_refetch got=%b exp=%b", obs, e);
        end
        cyc();
    endtask

    // Starts in EXECUTE; ends in reset-released FETCH_CURRENT.
    task automatic test_timeout();
        logic [10:0] e;
        memAck = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            e = {S_FETCH_NEXT, 8'b1000_0000};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL to_waiting iter=%0d got=%b exp=%b", i, obs, e);
            end
            cyc();
        end
        #1;
        e = {S_HALTED, 8'b0000_0111};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL to_bus_error got=%b exp=%b", obs, e);
        end
        exp_stall = 4'd7;
        checks++;
        if (stallCount !== exp_stall) begin
            failures++;
            $display("FAIL to_stall got=%0d exp=%0d", stallCount, exp_stall);
        end
        resume = 1'b1;
        cyc();
        cyc();
        resume = 1'b0;
        #1;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL to_resume_ignored got=%b exp=%b", obs, e);
        end
        reset = 1'b0;
        #1;
        e = {S_FETCH_CURRENT, 8'b0000_0001};
        checks++;
        if (obs !== e || stallCount !== 4'd0) begin
            failures++;
            $display("FAIL to_reset_clears got=%b stall=%0d exp=%b stall=0", obs, stallCount, e);
        end
        exp_stall = 4'd0;
        cyc();
        reset = 1'b1;
    endtask

    // Starts in FETCH_CURRENT; ack lands on the last allowed cycle; ends in EXECUTE.
    task automatic test_ack_on_final_cycle();
        logic [10:0] e;
        memAck = 1'b1;
        cyc();
        cyc();
        memAck = 1'b0;
        cyc();
        cyc();
        cyc();
        memAck = 1'b1;
        #1;
        e = {S_FETCH_NEXT, 8'b1011_0000};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL final_ack_advance got=%b exp=%b", obs, e);
        end
        cyc();
        #1;
        e = {S_EXECUTE, 8'b0000_0000};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL final_ack_no_error got=%b exp=%b", obs, e);
        end
        exp_stall = 4'd3;
        checks++;
        if (stallCount !== exp_stall) begin
            failures++;
            $display("FAIL final_ack_stall got=%0d exp=%0d", stallCount, exp_stall);
        end
    endtask

    // Seven data accesses with three waits each: 3 + 21 stalls saturates at 15.
    task automatic test_stall_saturation();
        for (int i = 0; i < 7; i++) begin
            dataAccessRequest = 1'b1;
            memAck = 1'b0;
            cyc();
            dataAccessRequest = 1'b0;
            cyc();
            cyc();
            cyc();
            memAck = 1'b1;
            cyc();
            cyc();
            exp_stall = (exp_stall > 4'd12) ? 4'd15 : exp_stall + 4'd3;
            checks++;
            if (stallCount !== exp_stall) begin
                failures++;
                $display("FAIL stall_sat iter=%0d got=%0d exp=%0d", i, stallCount, exp_stall);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [10:0] e;
        dataAccessRequest = 1'b1;
        memAck = 1'b0;
        cyc();
        dataAccessRequest = 1'b0;
        cyc();
        memAck = 1'b1;
        #1;
        e = {S_DATA_ACCESS, 8'b1100_1000};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL mid_before got=%b exp=%b", obs, e);
        end
        reset = 1'b0;
        #1;
        e = {S_FETCH_CURRENT, 8'b0000_0001};
        checks++;
        if (obs !== e || stallCount !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset got=%b stall=%0d exp=%b stall=0", obs, stallCount, e);
        end
        cyc();
        reset = 1'b1;
        #1;
        e = {S_FETCH_CURRENT, 8'b1001_0001};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL mid_release got=%b exp=%b", obs, e);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_back_to_back();
        test_data_access();
        test_halt_priority();
        test_timeout();
        test_ack_on_final_cycle();
        test_stall_saturation();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
